// File: rtl/bin_to_bcd_digits_pkg.sv
// Shared constants and types for the binary-to-BCD display front end.
package bin_to_bcd_digits_pkg;

    localparam int unsigned DISP_DIGITS = 4;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned DISP_MAX    = 9999;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    typedef struct packed {
        logic [BCD_W-1:0] d3;
        logic [BCD_W-1:0] d2;
        logic [BCD_W-1:0] d1;
        logic [BCD_W-1:0] d0;
    } bcd_digits_t;

endpackage

// File: rtl/bin_to_bcd_digits_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface bin_to_bcd_digits_if #(
    parameter int unsigned BIN_W = 14
);
    import bin_to_bcd_digits_pkg::*;

    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [BCD_W-1:0] D3;
    logic [BCD_W-1:0] D2;
    logic [BCD_W-1:0] D1;
    logic [BCD_W-1:0] D0;

    modport master (
        output start, bin,
        input  busy, done, ovf, D3, D2, D1, D0
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, D3, D2, D1, D0
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD nibble of 5 or more.
module bcd_add3
    import bin_to_bcd_digits_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_W'(5)) dout = din + BCD_W'(3);
    end

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the 4-digit display.
// Saturates at 9999 and holds the last result until the next conversion loads.
module bin_to_bcd_digits
    import bin_to_bcd_digits_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic                clk_100MHz,
    input  logic                rst,
    bin_to_bcd_digits_if.slave  bus
);

    localparam int unsigned BCD_BITS = DISP_DIGITS * BCD_W;
    localparam int unsigned SR_W     = BCD_BITS + BIN_W;
    localparam int unsigned CNT_W    = $clog2(BIN_W + 1);

    logic [1:0]       state_q,   state_d;
    logic [SR_W-1:0]  sr_q,      sr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             ovf_lat_q, ovf_lat_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             ovf_q,     ovf_d;
    bcd_digits_t      digits_q,  digits_d;

    logic             ovf_c;
    logic [BIN_W-1:0] sat_c;
    logic [BCD_BITS-1:0] bcd_corr_c;
    logic [SR_W-1:0]  sr_shift_c;

    // Compare at 32 bits so narrow BIN_W never truncates the 9999 limit.
    assign ovf_c = 32'(bus.bin) > 32'(DISP_MAX);
    assign sat_c = ovf_c ? BIN_W'(DISP_MAX) : bus.bin;

    for (genvar g = 0; g < int'(DISP_DIGITS); g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr_q[BIN_W + g*BCD_W +: BCD_W]),
            .dout (bcd_corr_c[g*BCD_W +: BCD_W])
        );
    end

    assign sr_shift_c = {bcd_corr_c[BCD_BITS-2:0], sr_q[BIN_W-1:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovf_lat_d = ovf_lat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        digits_d  = digits_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sr_d      = {BCD_BITS'(0), sat_c};
                    cnt_d     = '0;
                    ovf_lat_d = ovf_c;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_shift_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                digits_d = bcd_digits_t'(sr_q[BIN_W +: BCD_BITS]);
                ovf_d    = ovf_lat_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_lat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            digits_q  <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_lat_q <= ovf_lat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            digits_q  <= digits_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.D3   = digits_q.d3;
    assign bus.D2   = digits_q.d2;
    assign bus.D1   = digits_q.d1;
    assign bus.D0   = digits_q.d0;

endmodule
